// File: rtl/led_fade_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_fade_if : pattern-in / PWM-out bundle for the led_fade afterglow stage
// Rev 1.0
// ----------------------------------------------------------------------------
interface led_fade_if;
  logic       en;
  logic [7:0] led_in;
  logic [7:0] led_out;
  logic       active;

  modport master (output en, output led_in, input led_out, input active);
  modport slave  (input en, input led_in, output led_out, output active);
endinterface
`default_nettype wire

// File: rtl/led_fade.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_fade : 8-channel LED afterglow, instant attack, linear decay, shared PWM
// Rev 1.0
// ----------------------------------------------------------------------------
module led_fade #(
  parameter int PRESCALE_W = 16,
  parameter int DECAY      = 8
) (
  input  logic      clk,
  input  logic      rst,
  led_fade_if.slave bus
);

  localparam logic [7:0]            c_DECAY   = 8'(DECAY);
  localparam logic [7:0]            c_FULL    = 8'hFF;
  localparam logic [PRESCALE_W-1:0] c_PRE_TOP = {PRESCALE_W{1'b1}};

  logic [7:0]            in_q;
  logic [7:0]            pwm_q, pwm_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [7:0]            level_q [8];
  logic [7:0]            level_d [8];
  logic [7:0]            led_out_q, led_out_d;
  logic                  active_q, active_d;
  logic                  tick;

  always_comb begin
    pwm_d     = pwm_q;
    pre_d     = pre_q;
    tick      = bus.en && (pre_q == c_PRE_TOP);
    led_out_d = 8'h00;
    active_d  = 1'b0;
    if (bus.en) begin
      pwm_d = pwm_q + 8'd1;
      pre_d = pre_q + PRESCALE_W'(1);
    end
    for (int i = 0; i < 8; i++) begin
      level_d[i] = level_q[i];
      // Attack beats a coincident tick; decay saturates at zero.
      if (bus.en) begin
        if (in_q[i]) begin
          level_d[i] = c_FULL;
        end else if (tick) begin
          level_d[i] = (level_q[i] >= c_DECAY) ? (level_q[i] - c_DECAY) : 8'd0;
        end
      end
      led_out_d[i] = bus.en && (level_q[i] > pwm_q);
      active_d     = active_d | (level_q[i] != 8'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q      <= 8'h00;
      pwm_q     <= 8'h00;
      pre_q     <= '0;
      led_out_q <= 8'h00;
      active_q  <= 1'b0;
      for (int i = 0; i < 8; i++) level_q[i] <= 8'd0;
    end else begin
      in_q      <= bus.led_in;
      pwm_q     <= pwm_d;
      pre_q     <= pre_d;
      led_out_q <= led_out_d;
      active_q  <= active_d;
      for (int i = 0; i < 8; i++) level_q[i] <= level_d[i];
    end
  end

  assign bus.led_out = led_out_q;
  assign bus.active  = active_q;

endmodule
`default_nettype wire

// File: tb/tb_led_fade.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_led_fade : two instances (DECAY 64 / 32, 16-cycle tick) against a model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_led_fade;

  localparam int PW  = 4;
  localparam int PER = 1 << PW;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       en     = 1'b1;
  logic [7:0] led_in = 8'hFF;
  bit         chk_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  led_fade_if ifa ();
  led_fade_if ifb ();
  assign ifa.en = en;  assign ifa.led_in = led_in;
  assign ifb.en = en;  assign ifb.led_in = led_in;

  led_fade #(.PRESCALE_W(PW), .DECAY(64)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  led_fade #(.PRESCALE_W(PW), .DECAY(32)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  // Model: n counts enabled cycles since reset; PWM phase is n mod 256 and a
  // tick falls on every enabled edge where n mod 16 is 15.
  int         dec   [2] = '{64, 32};
  int         m_lvl [2][8];
  int         m_n   [2];
  logic [7:0] m_in  [2];
  logic [7:0] m_out [2];
  logic       m_act [2];
  bit         mt_any, mt_tick;

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_in[d] = 8'h00; m_out[d] = 8'h00; m_act[d] = 1'b0; m_n[d] = 0;
        for (int i = 0; i < 8; i++) m_lvl[d][i] = 0;
      end else begin
        mt_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
          mt_any      = mt_any | (m_lvl[d][i] != 0);
          m_out[d][i] = en && (m_lvl[d][i] > (m_n[d] % 256));
        end
        m_act[d] = mt_any;
        if (en) begin
          mt_tick = (m_n[d] % PER) == PER - 1;
          for (int i = 0; i < 8; i++) begin
            if (m_in[d][i])   m_lvl[d][i] = 255;
            else if (mt_tick) m_lvl[d][i] = (m_lvl[d][i] - dec[d] > 0) ? m_lvl[d][i] - dec[d] : 0;
          end
          m_n[d]++;
        end
        m_in[d] = led_in;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit dark(input int d);
    for (int i = 0; i < 8; i++) if (m_lvl[d][i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_dark(input int d, input string name);
    int k = 0;
    while (!dark(d) && k < 400) begin @(negedge clk); k++; end
    check(name, 32'(k < 400), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_led_out", 32'(ifa.led_out), 32'(m_out[0]));
      check("a_active",  32'(ifa.active),  32'(m_act[0]));
      check("b_led_out", 32'(ifb.led_out), 32'(m_out[1]));
      check("b_active",  32'(ifb.active),  32'(m_act[1]));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[$];
    int times[$];
    int prev, cnt, k, n0, p;
    int exp_seq [5] = '{255, 191, 127, 63, 0};

    // Reset held with all inputs high
    @(negedge clk);
    chk_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      check("rst_led_out", 32'(ifa.led_out), 32'h0);
      check("rst_active",  32'(ifa.active),  32'h0);
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("release_led_out_a", 32'(ifa.led_out), 32'hFF);
    check("release_led_out_b", 32'(ifb.led_out), 32'hFF);

    // Decay staircase on channel 0
    led_in = 8'h00;
    wait_dark(0, "decay_dark_wait");
    led_in = 8'h01;
    @(negedge clk);
    led_in = 8'h00;
    prev = m_lvl[0][0];
    for (int j = 0; j < 150 && vals.size() < 5; j++) begin
      @(negedge clk);
      if (m_lvl[0][0] != prev) begin
        prev = m_lvl[0][0];
        vals.push_back(prev);
        times.push_back(cyc);
        if (prev == 0) begin
          check("active_lag_hold", 32'(ifa.active), 32'd1);
          @(negedge clk);
          check("active_lag_fall", 32'(ifa.active), 32'd0);
        end
      end
    end
    check("decay_steps", 32'(vals.size()), 32'd5);
    if (vals.size() == 5) begin
      for (int j = 0; j < 5; j++) check("decay_level", 32'(vals[j]), 32'(exp_seq[j]));
      for (int j = 2; j < 5; j++) check("decay_spacing", 32'(times[j] - times[j-1]), 32'(PER));
    end

    // Duty at full and zero level
    led_in = 8'h01;
    repeat (4) @(negedge clk);
    cnt = 0;
    repeat (256) begin @(negedge clk); cnt += int'(ifa.led_out[0]); end
    check("duty_255", 32'(cnt), 32'd255);
    led_in = 8'h00;
    wait_dark(0, "duty_dark_wait");
    cnt = 0;
    repeat (256) begin @(negedge clk); cnt += int'(ifa.led_out[0]); end
    check("duty_0", 32'(cnt), 32'd0);

    // Re-assert channel 3 on a tick edge while at 127
    led_in = 8'h08;
    @(negedge clk);
    led_in = 8'h00;
    k = 0;
    while (m_lvl[0][3] != 127 && k < 100) begin @(negedge clk); k++; end
    check("reassert_reach_127", 32'(m_lvl[0][3]), 32'd127);
    k = 0;
    while ((m_n[0] % PER) != PER - 2 && k < 40) begin @(negedge clk); k++; end
    led_in = 8'h08;
    @(negedge clk);
    check("reassert_pre_tick", 32'(m_lvl[0][3]), 32'd127);
    @(negedge clk);
    check("reassert_tick_passed", 32'(m_n[0] % PER), 32'd0);
    check("reassert_level", 32'(m_lvl[0][3]), 32'd255);
    led_in = 8'h00;
    wait_dark(0, "reassert_dark_wait");

    // Enable gating with channel 5 at 191
    led_in = 8'h20;
    @(negedge clk);
    led_in = 8'h00;
    k = 0;
    while (m_lvl[0][5] != 191 && k < 100) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    n0 = m_n[0];
    p  = n0 % PER;
    en = 1'b0;
    repeat (40) begin
      @(negedge clk);
      check("gate_dark_a", 32'(ifa.led_out), 32'h0);
      check("gate_dark_b", 32'(ifb.led_out), 32'h0);
    end
    check("gate_hold_level", 32'(m_lvl[0][5]), 32'd191);
    check("gate_hold_count", 32'(m_n[0]), 32'(n0));
    en = 1'b1;
    k = 0;
    while (m_lvl[0][5] == 191 && k < 40) begin @(negedge clk); k++; end
    check("gate_resume_delay", 32'(k), 32'(PER - p));
    check("gate_resume_level", 32'(m_lvl[0][5]), 32'd127);

    // Random traffic with occasional enable drops and resets
    repeat (3000) begin
      @(negedge clk);
      led_in = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      en     = ($urandom_range(0, 15) != 0);
      rst    = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b1; led_in = 8'h00;
    wait_dark(1, "wave_dark_wait");

    // Walking one every 64 cycles
    for (int s = 0; s < 16; s++) begin
      int c, a, b, nz;
      c = s % 8; a = (c + 7) % 8; b = (c + 6) % 8;
      led_in = 8'(1 << c);
      repeat (64) begin
        @(negedge clk);
        nz = 0;
        for (int i = 0; i < 8; i++) nz += int'(m_lvl[1][i] != 0);
        check("wave_max3", 32'(nz <= 3), 32'd1);
        check("wave_order", 32'((m_lvl[1][a] > m_lvl[1][b]) ||
                                (m_lvl[1][a] == 0 && m_lvl[1][b] == 0)), 32'd1);
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
